// File: rtl/seq_alu.sv
// ============================================================================
// Module      : seq_alu
// Description : Multi-cycle N-bit ALU with start/busy/done handshake,
//               shift-add multiplier and restoring divider.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module seq_alu #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result_lo,
    output logic [N-1:0] result_hi,
    output logic         carry,
    output logic         zero,
    output logic         div_zero
);

    localparam int c_cnt_w = $clog2(N + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(N - 1);

    localparam logic [2:0] c_op_add = 3'b000;
    localparam logic [2:0] c_op_sub = 3'b001;
    localparam logic [2:0] c_op_and = 3'b010;
    localparam logic [2:0] c_op_or  = 3'b011;
    localparam logic [2:0] c_op_xor = 3'b100;
    localparam logic [2:0] c_op_mul = 3'b101;
    localparam logic [2:0] c_op_div = 3'b110;
    localparam logic [2:0] c_op_mod = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MUL_RUN = 2'd1,
        S_DIV_RUN = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_op;
    logic [N-1:0]       r_a;
    logic [N-1:0]       r_b;
    // Shared by both engines: product high half / partial remainder
    logic [N-1:0]       r_acc;
    // Multiplier bits being consumed / dividend bits becoming quotient
    logic [N-1:0]       r_q;

    logic [N:0]         w_add;
    logic [N-1:0]       w_alu_lo;
    logic               w_alu_carry;
    logic [N:0]         w_mul_sum;
    logic [N-1:0]       w_mul_acc;
    logic [N-1:0]       w_mul_q;
    logic [N:0]         w_trial;
    logic               w_fits;
    logic [N:0]         w_div_diff;
    logic [N-1:0]       w_div_rem;
    logic [N-1:0]       w_div_q;
    logic               w_is_div;

    always_comb begin
        w_add       = {1'b0, a} + {1'b0, b};
        w_alu_lo    = '0;
        w_alu_carry = 1'b0;
        case (op)
            c_op_add: begin
                w_alu_lo    = w_add[N-1:0];
                w_alu_carry = w_add[N];
            end
            c_op_sub: begin
                w_alu_lo    = a - b;
                w_alu_carry = (a >= b);
            end
            c_op_and: w_alu_lo = a & b;
            c_op_or:  w_alu_lo = a | b;
            c_op_xor: w_alu_lo = a ^ b;
            default:  w_alu_lo = '0;
        endcase
    end

    // One shift-add step: conditionally add multiplicand, then shift {acc,q} right
    always_comb begin
        w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_a} : {(N+1){1'b0}});
        w_mul_acc = w_mul_sum[N:1];
        w_mul_q   = {w_mul_sum[0], r_q[N-1:1]};
    end

    // One restoring step: shift next dividend bit into the remainder and try b
    always_comb begin
        w_trial    = {r_acc, r_q[N-1]};
        w_fits     = (w_trial >= {1'b0, r_b});
        w_div_diff = w_trial - {1'b0, r_b};
        w_div_rem  = w_fits ? w_div_diff[N-1:0] : w_trial[N-1:0];
        w_div_q    = {r_q[N-2:0], w_fits};
    end

    assign w_is_div = (op == c_op_div) || (op == c_op_mod);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op  <= op;
                        r_a   <= a;
                        r_b   <= b;
                        r_cnt <= '0;
                        if (op == c_op_mul) begin
                            r_acc   <= '0;
                            r_q     <= b;
                            busy    <= 1'b1;
                            r_state <= S_MUL_RUN;
                        end else if (w_is_div && (b != '0)) begin
                            r_acc   <= '0;
                            r_q     <= a;
                            busy    <= 1'b1;
                            r_state <= S_DIV_RUN;
                        end else if (w_is_div) begin
                            result_lo <= '1;
                            result_hi <= a;
                            carry     <= 1'b0;
                            zero      <= 1'b0;
                            div_zero  <= 1'b1;
                            done      <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            result_lo <= w_alu_lo;
                            result_hi <= '0;
                            carry     <= w_alu_carry;
                            zero      <= (w_alu_lo == '0);
                            div_zero  <= 1'b0;
                            done      <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_MUL_RUN: begin
                    r_acc <= w_mul_acc;
                    r_q   <= w_mul_q;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last) begin
                        result_lo <= w_mul_q;
                        result_hi <= w_mul_acc;
                        carry     <= 1'b0;
                        zero      <= ({w_mul_acc, w_mul_q} == '0);
                        div_zero  <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DIV_RUN: begin
                    r_acc <= w_div_rem;
                    r_q   <= w_div_q;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last) begin
                        if (r_op == c_op_div) begin
                            result_lo <= w_div_q;
                            result_hi <= w_div_rem;
                            zero      <= (w_div_q == '0);
                        end else begin
                            result_lo <= w_div_rem;
                            result_hi <= w_div_q;
                            zero      <= (w_div_rem == '0);
                        end
                        carry    <= 1'b0;
                        div_zero <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
